// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_if
//  Description : Bundle between the digit-counter stage and the display
//                scanner: packed digit values and per-digit masks in,
//                anode/segment/decimal-point pins out.
//                master = digit producer / board side, slave = seg_scan.
//                With SEG_BLINK_EN defined an edit_mask member is added.
//  Signals     : digits[4*NDIG-1:0]  digit i = digits[4i+3:4i]
//                dp_mask[NDIG-1:0]   1 = decimal point lit on digit i
//                blank_mask[NDIG-1:0] 1 = digit i fully dark
//                edit_mask[NDIG-1:0] 1 = digit i blinks (SEG_BLINK_EN only)
//                an[NDIG-1:0]        anode enables, active-high
//                seg[6:0]            segments a..g, active-high
//                dp                  decimal point, active-high
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp_mask;
    logic [NDIG-1:0]   blank_mask;
`ifdef SEG_BLINK_EN
    logic [NDIG-1:0]   edit_mask;
`endif
    logic [NDIG-1:0]   an;
    logic [6:0]        seg;
    logic              dp;

    modport master (
        output digits, dp_mask, blank_mask,
`ifdef SEG_BLINK_EN
        output edit_mask,
`endif
        input  an, seg, dp
    );

    modport slave (
        input  digits, dp_mask, blank_mask,
`ifdef SEG_BLINK_EN
        input  edit_mask,
`endif
        output an, seg, dp
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan
//  Description : Time-multiplexed 7-segment display driver. Scans one digit
//                per slot (DIV = CLK_HZ/SCAN_HZ clocks), decodes hex to
//                segments, applies per-digit blank and decimal point, and
//                drops the anode for the last DEAD_CYC clocks of every slot
//                to avoid ghosting on the next digit.
//                Optional feature macro: SEG_BLINK_EN (adds edit_mask and a
//                blink phase that periodically blanks the edited digits).
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - seg_scan_if.slave (digits, masks in; an/seg/dp out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int NDIG     = 4,
    parameter int DEAD_CYC = 16
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_HZ = 2
`endif
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    seg_scan_if.slave   bus
);
    localparam int C_DIV = CLK_HZ / SCAN_HZ;
    localparam int C_CW  = $clog2(C_DIV + 1);
    localparam int C_IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [C_CW-1:0] C_DIV_LAST   = C_CW'(C_DIV - 1);
    localparam logic [C_CW-1:0] C_DEAD_START = C_CW'(C_DIV - DEAD_CYC);
    localparam logic [C_IW-1:0] C_IDX_LAST   = C_IW'(NDIG - 1);

    logic [C_CW-1:0] r_div;
    logic [C_IW-1:0] r_idx;
    logic [NDIG-1:0] r_slot_an;
    logic [6:0]      r_seg;
    logic            r_dp;

    logic            w_tick;
    logic            w_dead;
    logic [C_IW-1:0] w_idx_nxt;
    logic [3:0]      w_digit;
    logic [6:0]      w_dec;
    logic            w_blank;

    assign w_tick    = (r_div == C_DIV_LAST);
    assign w_idx_nxt = (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
    assign w_digit   = bus.digits[4*w_idx_nxt +: 4];

    // Anode is the only pin cut during dead time; seg/dp keep their value so
    // the segment drivers never switch while a digit is lit.
    assign w_dead = (DEAD_CYC != 0) && (r_div >= C_DEAD_START);

`ifdef SEG_BLINK_EN
    localparam int C_BHALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int C_BW    = $clog2(C_BHALF + 1);
    localparam logic [C_BW-1:0] C_BHALF_LAST = C_BW'(C_BHALF - 1);

    logic [C_BW-1:0] r_blink_cnt;
    logic            r_phase;

    // Free-running blink timebase, independent of the scan divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == C_BHALF_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank = bus.blank_mask[w_idx_nxt] | (r_phase & bus.edit_mask[w_idx_nxt]);
`else
    assign w_blank = bus.blank_mask[w_idx_nxt];
`endif

    always_comb begin
        w_dec = 7'h00;
        case (w_digit)
            4'h0: w_dec = 7'h3F;
            4'h1: w_dec = 7'h06;
            4'h2: w_dec = 7'h5B;
            4'h3: w_dec = 7'h4F;
            4'h4: w_dec = 7'h66;
            4'h5: w_dec = 7'h6D;
            4'h6: w_dec = 7'h7D;
            4'h7: w_dec = 7'h07;
            4'h8: w_dec = 7'h7F;
            4'h9: w_dec = 7'h6F;
            4'hA: w_dec = 7'h77;
            4'hB: w_dec = 7'h7C;
            4'hC: w_dec = 7'h39;
            4'hD: w_dec = 7'h5E;
            4'hE: w_dec = 7'h79;
            4'hF: w_dec = 7'h71;
            default: w_dec = 7'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Everything shown in a slot is captured once at the slot boundary, so
    // input changes mid-slot cannot glitch the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_slot_an <= '0;
            r_seg     <= '0;
            r_dp      <= 1'b0;
        end else if (w_tick) begin
            r_idx     <= w_idx_nxt;
            r_slot_an <= w_blank ? '0 : (NDIG'(1) << w_idx_nxt);
            r_seg     <= w_blank ? 7'h00 : w_dec;
            r_dp      <= bus.dp_mask[w_idx_nxt] & ~w_blank;
        end
    end

    assign bus.an  = w_dead ? '0 : r_slot_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan
//  Description : Directed self-checking bench for seg_scan with
//                CLK_HZ=1000, SCAN_HZ=100 (DIV=10), DEAD_CYC=2, NDIG=4.
//                With SEG_BLINK_EN defined, BLINK_HZ=5 and a blink step runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    seg_scan_if #(.NDIG(4)) bus ();

    seg_scan #(
        .CLK_HZ   (1000),
        .SCAN_HZ  (100),
        .NDIG     (4),
        .DEAD_CYC (2)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_HZ (5)
`endif
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a slot-load edge (div_cnt=0); returns just after the
    // next slot-load edge.
    task automatic slot(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
        chk({tag, "_an"},  16'(bus.an),  16'(a));
        chk({tag, "_seg"}, 16'(bus.seg), 16'(s));
        chk({tag, "_dp"},  16'(bus.dp),  16'(d));
        for (int i = 1; i < 10; i++) begin
            step(1);
            chk({tag, "_onehot"}, 16'($countones(bus.an) <= 1), 16'd1);
            if (i == 7)
                chk({tag, "_an_late"}, 16'(bus.an), 16'(a));
            if (i >= 8) begin
                chk({tag, "_an_dead"},  16'(bus.an),  16'd0);
                chk({tag, "_seg_dead"}, 16'(bus.seg), 16'(s));
                chk({tag, "_dp_dead"},  16'(bus.dp),  16'(d));
            end
        end
        step(1);
    endtask

    // Releases reset at a falling edge, checks outputs stay dark until the
    // first tick, and returns just after the edge that loads idx 1.
    task automatic release_and_first(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        step(9);
        chk({tag, "_pre_an"},  16'(bus.an),  16'd0);
        chk({tag, "_pre_seg"}, 16'(bus.seg), 16'd0);
        step(1);
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.digits      = 16'h4321;
        bus.dp_mask     = 4'b0000;
        bus.blank_mask  = 4'b0000;
`ifdef SEG_BLINK_EN
        bus.edit_mask   = 4'b0000;
`endif
        step(3);
        chk("rst_an",  16'(bus.an),  16'd0);
        chk("rst_seg", 16'(bus.seg), 16'd0);
        chk("rst_dp",  16'(bus.dp),  16'd0);

        // Scan order 1,2,3,0 for 16'h4321
        release_and_first("first");
        slot("s1", 4'b0010, 7'h5B, 1'b0);
        slot("s2", 4'b0100, 7'h4F, 1'b0);
        slot("s3", 4'b1000, 7'h66, 1'b0);
        slot("s0", 4'b0001, 7'h06, 1'b0);
        slot("s1r", 4'b0010, 7'h5B, 1'b0);

        // Slot 2 already loaded: the new inputs only show from slot 3 on
        bus.digits     = 16'hF0A0;
        bus.blank_mask = 4'b0001;
        bus.dp_mask    = 4'b0100;
        slot("hold2", 4'b0100, 7'h4F, 1'b0);
        slot("f3",    4'b1000, 7'h71, 1'b0);
        slot("blk0",  4'b0000, 7'h00, 1'b0);
        slot("a1",    4'b0010, 7'h77, 1'b0);
        slot("dp2",   4'b0100, 7'h3F, 1'b1);

        // Unblank digit 0, then change it mid-slot 0
        bus.blank_mask = 4'b0000;
        slot("f3b",  4'b1000, 7'h71, 1'b0);
        bus.digits[3:0] = 4'h8;
        slot("mid0", 4'b0001, 7'h3F, 1'b0);
        slot("a1b",  4'b0010, 7'h77, 1'b0);
        slot("dp2b", 4'b0100, 7'h3F, 1'b1);
        slot("f3c",  4'b1000, 7'h71, 1'b0);
        slot("new0", 4'b0001, 7'h7F, 1'b0);

        // Asynchronous reset mid-slot clears the pins without a clock edge
        step(3);
        rst_n = 1'b0;
        #1;
        chk("arst_an",  16'(bus.an),  16'd0);
        chk("arst_seg", 16'(bus.seg), 16'd0);
        chk("arst_dp",  16'(bus.dp),  16'd0);
        bus.digits  = 16'h4321;
        bus.dp_mask = 4'b0000;
        step(2);
        release_and_first("rel2");
        slot("r1", 4'b0010, 7'h5B, 1'b0);
        slot("r2", 4'b0100, 7'h4F, 1'b0);

`ifdef SEG_BLINK_EN
        // Half blink period is 100 clocks; digit 1 loads at edges 10+40k
        rst_n = 1'b0;
        bus.edit_mask = 4'b0010;
        step(2);
        release_and_first("blink");
        chk("blink_vis_an",  16'(bus.an),  16'b0010);
        step(120);
        chk("blink_dark_an",  16'(bus.an),  16'd0);
        chk("blink_dark_seg", 16'(bus.seg), 16'd0);
        step(80);
        chk("blink_back_an",  16'(bus.an),  16'b0010);
        chk("blink_back_seg", 16'(bus.seg), 16'h5B);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
